// File: rtl/cdb_arbiter.sv
// cdb_arbiter: puts completing functional-unit results onto the single common data bus (CDB).
//
// Each FU owns a one-entry holding buffer. A round-robin arbiter picks one occupied buffer per
// cycle. The pick drives a registered CDB broadcast of the value and ROB tag.
//
// Ports
//   clock       rising-edge system clock
//   reset       asynchronous, active-high; clears all state
//   flush       synchronous squash; clears the buffers, the round-robin pointer and the CDB
//   fu_done     per-FU "result presented this cycle"
//   fu_result   per-FU result, slice [i*XLEN +: XLEN]
//   fu_tag      per-FU destination ROB tag, slice [i*TAG_W +: TAG_W]
//   fu_stall    buffer i is full and not granted; FU i must hold its result
//   cdb_select  one-hot grant for this cycle, decoded from registered state only
//   cdb_valid   registered: the CDB carries a result
//   cdb_value   registered broadcast value
//   cdb_tag     registered broadcast ROB tag

// One FU holding buffer. load and clear are mutually exclusive by construction in the parent.
module cdb_fu_buf #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             load,
   input  logic             clear,
   input  logic [XLEN-1:0]  in_value,
   input  logic [TAG_W-1:0] in_tag,
   output logic             buf_valid,
   output logic [XLEN-1:0]  buf_value,
   output logic [TAG_W-1:0] buf_tag
);
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_value <= '0;
         buf_tag   <= '0;
      end else if (flush) begin
         buf_valid <= 1'b0;          // squash wins over a result arriving this cycle
      end else if (load) begin
         buf_valid <= 1'b1;
         buf_value <= in_value;
         buf_tag   <= in_tag;
      end else if (clear) begin
         buf_valid <= 1'b0;
      end
   end
endmodule

module cdb_arbiter #(
   parameter int NUM_FU = 4,
   parameter int XLEN   = 32,
   parameter int TAG_W  = 5
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [NUM_FU-1:0]       fu_done,
   input  logic [NUM_FU*XLEN-1:0]  fu_result,
   input  logic [NUM_FU*TAG_W-1:0] fu_tag,
   output logic [NUM_FU-1:0]       fu_stall,
   output logic [NUM_FU-1:0]       cdb_select,
   output logic                    cdb_valid,
   output logic [XLEN-1:0]         cdb_value,
   output logic [TAG_W-1:0]        cdb_tag
);
   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0]             buf_valid;
   logic [NUM_FU-1:0][XLEN-1:0]   buf_value;
   logic [NUM_FU-1:0][TAG_W-1:0]  buf_tag;
   logic [NUM_FU-1:0]             buf_load;
   logic [NUM_FU-1:0]             buf_clear;

   logic [PTR_W-1:0]              rr_ptr;
   logic [PTR_W-1:0]              gnt_idx;
   logic [PTR_W-1:0]              scan_idx;
   logic                          gnt_any;
   int                            scan;

   // An FU may load into an empty buffer, or into one that drains this cycle.
   // A drain plus a refill in the same cycle gives back-to-back broadcasts.
   assign buf_load  = fu_done & (~buf_valid | cdb_select);
   assign buf_clear = cdb_select & ~fu_done;
   assign fu_stall  = buf_valid & ~cdb_select;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_buf
      cdb_fu_buf #(.XLEN(XLEN), .TAG_W(TAG_W)) u_buf (
         .clock     (clock),
         .reset     (reset),
         .flush     (flush),
         .load      (buf_load[i]),
         .clear     (buf_clear[i]),
         .in_value  (fu_result[i*XLEN +: XLEN]),
         .in_tag    (fu_tag[i*TAG_W +: TAG_W]),
         .buf_valid (buf_valid[i]),
         .buf_value (buf_value[i]),
         .buf_tag   (buf_tag[i])
      );
   end

   // Round-robin scan. Start at rr_ptr and wrap modulo NUM_FU. The first occupied buffer wins.
   always_comb begin
      gnt_any    = 1'b0;
      gnt_idx    = '0;
      scan       = 0;
      scan_idx   = '0;
      cdb_select = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan = int'(rr_ptr) + k;
         if (scan >= NUM_FU) scan = scan - NUM_FU;
         scan_idx = PTR_W'(scan);
         if (!gnt_any && buf_valid[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
         end
      end
      if (gnt_any) cdb_select[gnt_idx] = 1'b1;
   end

   // CDB register and pointer. value/tag hold when idle; only valid drops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_value <= '0;
         cdb_tag   <= '0;
      end else if (flush) begin
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_value <= '0;
         cdb_tag   <= '0;
      end else if (gnt_any) begin
         rr_ptr    <= (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + PTR_W'(1);
         cdb_valid <= 1'b1;
         cdb_value <= buf_value[gnt_idx];
         cdb_tag   <= buf_tag[gnt_idx];
      end else begin
         cdb_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter. Stimulus pushes each expected broadcast ({tag, value}) into a
// scoreboard queue. A negedge monitor pops an entry and compares it whenever cdb_valid is high.
// The main thread also checks grant/stall/valid cycle by cycle against hand-derived values.
module tb_cdb_arbiter;
   localparam int NUM_FU = 4;
   localparam int XLEN   = 32;
   localparam int TAG_W  = 5;

   logic                    clock;
   logic                    reset;
   logic                    flush;
   logic [NUM_FU-1:0]       fu_done;
   logic [NUM_FU*XLEN-1:0]  fu_result;
   logic [NUM_FU*TAG_W-1:0] fu_tag;
   logic [NUM_FU-1:0]       fu_stall;
   logic [NUM_FU-1:0]       cdb_select;
   logic                    cdb_valid;
   logic [XLEN-1:0]         cdb_value;
   logic [TAG_W-1:0]        cdb_tag;

   int n_tests = 0;
   int n_fail  = 0;
   logic [TAG_W+XLEN-1:0] sb[$];

   cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .fu_done(fu_done), .fu_result(fu_result), .fu_tag(fu_tag),
      .fu_stall(fu_stall), .cdb_select(cdb_select),
      .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_tag(cdb_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] rv(input int t);
      return 32'h1234_0000 + 32'(t);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      fu_done = '0;
   endtask

   task automatic put(input int i, input int t, input logic [31:0] v);
      fu_done[i]                 = 1'b1;
      fu_result[i*XLEN +: XLEN]  = v;
      fu_tag[i*TAG_W +: TAG_W]   = TAG_W'(t);
   endtask

   task automatic expect_bc(input int t, input logic [31:0] v);
      sb.push_back({TAG_W'(t), v});
   endtask

   // Scoreboard monitor
   always @(negedge clock) begin
      logic [TAG_W+XLEN-1:0] ent;
      if (!reset && cdb_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_broadcast: got tag %0d value %h, expected none", cdb_tag, cdb_value);
         end else begin
            ent = sb.pop_front();
            chk("bc_value", cdb_value, ent[XLEN-1:0]);
            chk("bc_tag", 32'(cdb_tag), 32'(ent[TAG_W+XLEN-1:XLEN]));
         end
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0;
      fu_done = '0; fu_result = '0; fu_tag = '0;
      #2;
      chk("rst_valid", 32'(cdb_valid), 0);
      chk("rst_select", 32'(cdb_select), 0);
      chk("rst_stall", 32'(fu_stall), 0);
      chk("rst_value", cdb_value, 0);
      chk("rst_tag", 32'(cdb_tag), 0);
      step(); reset = 1'b0;
      step();

      // 1: single result from FU2
      put(2, 7, 32'hDEAD_BEEF); expect_bc(7, 32'hDEAD_BEEF);
      step(); clr();
      chk("t1_select", 32'(cdb_select), 32'b0100);
      chk("t1_stall", 32'(fu_stall), 0);
      step();
      chk("t1_valid", 32'(cdb_valid), 1);
      step();
      chk("t1_idle_valid", 32'(cdb_valid), 0);
      chk("t1_idle_select", 32'(cdb_select), 0);
      chk("t1_value_hold", cdb_value, 32'hDEAD_BEEF);
      flush = 1'b1; step(); flush = 1'b0;
      chk("flush_value", cdb_value, 0);
      chk("flush_tag", 32'(cdb_tag), 0);

      // 2: full contention from rr_ptr=0
      for (int i = 0; i < 4; i++) begin put(i, i + 1, rv(i + 1)); expect_bc(i + 1, rv(i + 1)); end
      step(); clr();
      chk("t2_sel_c2", 32'(cdb_select), 32'b0001);
      chk("t2_stall_c2", 32'(fu_stall), 32'b1110);
      step();
      chk("t2_sel_c3", 32'(cdb_select), 32'b0010);
      chk("t2_stall_c3", 32'(fu_stall), 32'b1100);
      step();
      chk("t2_sel_c4", 32'(cdb_select), 32'b0100);
      step();
      chk("t2_sel_c5", 32'(cdb_select), 32'b1000);
      chk("t2_stall_c5", 32'(fu_stall), 0);
      step();
      chk("t2_sel_c6", 32'(cdb_select), 0);
      chk("t2_valid_c6", 32'(cdb_valid), 1);
      step();
      chk("t2_valid_c7", 32'(cdb_valid), 0);

      // 3: FU0 streaming, FU1 once; FU0 holds tag 12 while stalled
      put(0, 10, rv(10)); put(1, 20, rv(20));
      expect_bc(10, rv(10)); expect_bc(20, rv(20)); expect_bc(11, rv(11));
      expect_bc(12, rv(12)); expect_bc(13, rv(13));
      step(); clr(); put(0, 11, rv(11));
      chk("t3_sel_c2", 32'(cdb_select), 32'b0001);
      step(); clr(); put(0, 12, rv(12));
      chk("t3_sel_c3", 32'(cdb_select), 32'b0010);
      chk("t3_stall_c3", 32'(fu_stall), 32'b0001);
      chk("t3_valid_c3", 32'(cdb_valid), 1);
      step();
      chk("t3_sel_c4", 32'(cdb_select), 32'b0001);
      chk("t3_valid_c4", 32'(cdb_valid), 1);
      step(); clr(); put(0, 13, rv(13));
      chk("t3_sel_c5", 32'(cdb_select), 32'b0001);
      chk("t3_valid_c5", 32'(cdb_valid), 1);
      step(); clr();
      chk("t3_valid_c6", 32'(cdb_valid), 1);
      step();
      chk("t3_valid_c7", 32'(cdb_valid), 1);
      step();
      chk("t3_valid_c8", 32'(cdb_valid), 0);

      // 4: FU3 every cycle, back-to-back drain+refill
      for (int k = 0; k < 6; k++) begin
         if (k >= 1) begin
            chk("t4_sel", 32'(cdb_select), 32'b1000);
            chk("t4_stall", 32'(fu_stall), 0);
         end
         if (k >= 2) chk("t4_valid", 32'(cdb_valid), 1);
         clr(); put(3, k, rv(k)); expect_bc(k, rv(k));
         step();
      end
      clr();
      chk("t4_sel_tail", 32'(cdb_select), 32'b1000);
      chk("t4_valid_tail", 32'(cdb_valid), 1);
      step();
      chk("t4_valid_last", 32'(cdb_valid), 1);
      step();
      chk("t4_valid_end", 32'(cdb_valid), 0);

      // 5: flush with all buffers full; FU0 result in the flush cycle is dropped
      for (int i = 0; i < 4; i++) put(i, 21 + i, rv(21 + i));
      step(); clr();
      chk("t5_sel_c2", 32'(cdb_select), 32'b0001);
      flush = 1'b1; put(0, 25, rv(25));
      step(); flush = 1'b0; clr();
      chk("t5_valid", 32'(cdb_valid), 0);
      chk("t5_select", 32'(cdb_select), 0);
      chk("t5_stall", 32'(fu_stall), 0);
      put(0, 26, rv(26)); put(1, 27, rv(27));
      expect_bc(26, rv(26)); expect_bc(27, rv(27));
      step(); clr();
      chk("t5_rr_reset", 32'(cdb_select), 32'b0001);
      step();
      chk("t5_sel_next", 32'(cdb_select), 32'b0010);
      step(); step();

      // 6: async reset mid-contention (rr_ptr=2 here)
      for (int i = 0; i < 4; i++) put(i, 11 + i, rv(50 + i));
      step(); clr();
      chk("t6_sel", 32'(cdb_select), 32'b0100);
      expect_bc(13, rv(52));
      step();
      chk("t6_valid_pre", 32'(cdb_valid), 1);
      #5;
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(cdb_valid), 0);
      chk("t6_rst_select", 32'(cdb_select), 0);
      chk("t6_rst_stall", 32'(fu_stall), 0);
      chk("t6_rst_tag", 32'(cdb_tag), 0);
      reset = 1'b0;
      step();
      put(1, 9, rv(9)); expect_bc(9, rv(9));
      step(); clr();
      chk("t6_new_valid_c1", 32'(cdb_valid), 0);
      chk("t6_new_sel", 32'(cdb_select), 32'b0010);
      step();
      chk("t6_new_valid_c2", 32'(cdb_valid), 1);
      chk("t6_new_tag", 32'(cdb_tag), 9);
      step();
      chk("t6_new_valid_c3", 32'(cdb_valid), 0);
      step(); step();
      chk("sb_drained", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
